// File: rtl/eight_queen_pkg.sv
// Shared definitions for the eight_queen solver and its solution checker:
// board geometry, checker error codes and checker states.
package eight_queen_pkg;

  localparam int unsigned N         = 8;
  localparam int unsigned IDX_W     = $clog2(N);
  localparam int unsigned NUM_PAIRS = N * (N - 1) / 2;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_COL    = 2'b10;
  localparam logic [1:0] ERR_DIAG   = 2'b11;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_CHECK,
    S_REPORT
  } chk_state_e;

  // Column distance as an unsigned compare-and-swap subtraction.
  function automatic logic [IDX_W-1:0] abs_diff(input logic [IDX_W-1:0] x,
                                                input logic [IDX_W-1:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/queen_solution_checker_onehot.sv
// Converts a one-hot column mask to a column index; zero-hot and multi-hot
// masks are flagged as not one-hot.
module onehot_to_index
  import eight_queen_pkg::*;
(
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] index,
  output logic             is_onehot
);

  logic [IDX_W:0] ones;

  always_comb begin
    index = '0;
    ones  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i]) begin
        index = index | IDX_W'(i);
        ones  = ones + (IDX_W + 1)'(1);
      end
    end
    is_onehot = (ones == (IDX_W + 1)'(1));
  end

endmodule

// File: rtl/queen_solution_checker.sv
// Collects an N-row candidate board and checks it for row, column and
// diagonal legality one queen pair per cycle; counts legal boards.
module queen_solution_checker
  import eight_queen_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             user_reset,
  input  logic             row_valid,
  input  logic [N-1:0]     row_bus,
  output logic             row_ready,
  input  logic             frame_clear,
  output logic             busy,
  output logic             result_valid,
  output logic             result_ok,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] err_row_a,
  output logic [IDX_W-1:0] err_row_b,
  output logic [CNT_W-1:0] solution_count
);

  chk_state_e       state_q, state_d;
  logic [IDX_W-1:0] row_cnt_q, row_cnt_d;
  logic [IDX_W-1:0] cols_q [N];
  logic [IDX_W-1:0] cols_d [N];
  logic             bad_q, bad_d;
  logic [IDX_W-1:0] bad_row_q, bad_row_d;
  logic [IDX_W-1:0] pair_i_q, pair_i_d;
  logic [IDX_W-1:0] pair_j_q, pair_j_d;
  logic [1:0]       pend_code_q, pend_code_d;
  logic [IDX_W-1:0] pend_a_q, pend_a_d;
  logic [IDX_W-1:0] pend_b_q, pend_b_d;
  logic             result_valid_q, result_valid_d;
  logic             result_ok_q, result_ok_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [IDX_W-1:0] err_row_a_q, err_row_a_d;
  logic [IDX_W-1:0] err_row_b_q, err_row_b_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] row_idx;
  logic             row_onehot;
  logic [IDX_W-1:0] col_i, col_j, row_dist;
  logic             last_pair;

  onehot_to_index u_onehot (
    .mask      (row_bus),
    .index     (row_idx),
    .is_onehot (row_onehot)
  );

  assign col_i     = cols_q[pair_i_q];
  assign col_j     = cols_q[pair_j_q];
  assign row_dist  = pair_j_q - pair_i_q;
  assign last_pair = (pair_i_q == IDX_W'(N - 2));

  always_comb begin
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    cols_d         = cols_q;
    bad_d          = bad_q;
    bad_row_d      = bad_row_q;
    pair_i_d       = pair_i_q;
    pair_j_d       = pair_j_q;
    pend_code_d    = pend_code_q;
    pend_a_d       = pend_a_q;
    pend_b_d       = pend_b_q;
    result_valid_d = 1'b0;
    result_ok_d    = result_ok_q;
    err_code_d     = err_code_q;
    err_row_a_d    = err_row_a_q;
    err_row_b_d    = err_row_b_q;
    count_d        = count_q;

    case (state_q)
      S_COLLECT: begin
        if (frame_clear) begin
          row_cnt_d = '0;
          bad_d     = 1'b0;
        end else if (row_valid) begin
          cols_d[row_cnt_q] = row_idx;
          if (!row_onehot && !bad_q) begin
            bad_d     = 1'b1;
            bad_row_d = row_cnt_q;
          end
          if (row_cnt_q == IDX_W'(N - 1)) begin
            row_cnt_d = '0;
            // A bad last row must be seen here too, since bad_q lags by one edge.
            if (bad_q || !row_onehot) begin
              state_d     = S_REPORT;
              pend_code_d = ERR_ONEHOT;
              pend_a_d    = bad_q ? bad_row_q : row_cnt_q;
              pend_b_d    = bad_q ? bad_row_q : row_cnt_q;
            end else begin
              state_d  = S_CHECK;
              pair_i_d = '0;
              pair_j_d = IDX_W'(1);
            end
          end else begin
            row_cnt_d = row_cnt_q + IDX_W'(1);
          end
        end
      end

      S_CHECK: begin
        if (col_i == col_j) begin
          state_d     = S_REPORT;
          pend_code_d = ERR_COL;
          pend_a_d    = pair_i_q;
          pend_b_d    = pair_j_q;
        end else if (abs_diff(col_i, col_j) == row_dist) begin
          state_d     = S_REPORT;
          pend_code_d = ERR_DIAG;
          pend_a_d    = pair_i_q;
          pend_b_d    = pair_j_q;
        end else if (last_pair) begin
          state_d     = S_REPORT;
          pend_code_d = ERR_OK;
          pend_a_d    = '0;
          pend_b_d    = '0;
        end else if (pair_j_q == IDX_W'(N - 1)) begin
          pair_i_d = pair_i_q + IDX_W'(1);
          pair_j_d = pair_i_q + IDX_W'(2);
        end else begin
          pair_j_d = pair_j_q + IDX_W'(1);
        end
      end

      S_REPORT: begin
        result_valid_d = 1'b1;
        result_ok_d    = (pend_code_q == ERR_OK);
        err_code_d     = pend_code_q;
        err_row_a_d    = pend_a_q;
        err_row_b_d    = pend_b_q;
        if ((pend_code_q == ERR_OK) && (count_q != '1)) begin
          count_d = count_q + CNT_W'(1);
        end
        state_d   = S_COLLECT;
        row_cnt_d = '0;
        bad_d     = 1'b0;
      end

      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (user_reset) begin
      state_q        <= S_COLLECT;
      row_cnt_q      <= '0;
      cols_q         <= '{default: '0};
      bad_q          <= 1'b0;
      bad_row_q      <= '0;
      pair_i_q       <= '0;
      pair_j_q       <= '0;
      pend_code_q    <= ERR_OK;
      pend_a_q       <= '0;
      pend_b_q       <= '0;
      result_valid_q <= 1'b0;
      result_ok_q    <= 1'b0;
      err_code_q     <= ERR_OK;
      err_row_a_q    <= '0;
      err_row_b_q    <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      cols_q         <= cols_d;
      bad_q          <= bad_d;
      bad_row_q      <= bad_row_d;
      pair_i_q       <= pair_i_d;
      pair_j_q       <= pair_j_d;
      pend_code_q    <= pend_code_d;
      pend_a_q       <= pend_a_d;
      pend_b_q       <= pend_b_d;
      result_valid_q <= result_valid_d;
      result_ok_q    <= result_ok_d;
      err_code_q     <= err_code_d;
      err_row_a_q    <= err_row_a_d;
      err_row_b_q    <= err_row_b_d;
      count_q        <= count_d;
    end
  end

  assign row_ready      = (state_q == S_COLLECT);
  assign busy           = (state_q != S_COLLECT);
  assign result_valid   = result_valid_q;
  assign result_ok      = result_ok_q;
  assign err_code       = err_code_q;
  assign err_row_a      = err_row_a_q;
  assign err_row_b      = err_row_b_q;
  assign solution_count = count_q;

endmodule

// File: tb/tb_queen_solution_checker.sv
// Bench for queen_solution_checker: board-level reference model checked every
// cycle, plus directed boards with literal latency/code expectations.
module tb_queen_solution_checker;
  import eight_queen_pkg::*;

  logic       clk = 1'b0;
  logic       user_reset, row_valid, frame_clear;
  logic [7:0] row_bus;

  logic       row_ready, busy, result_valid, result_ok;
  logic [1:0] err_code;
  logic [2:0] err_row_a, err_row_b;
  logic [7:0] solution_count;

  logic       row_ready2, busy2, result_valid2, result_ok2;
  logic [1:0] err_code2;
  logic [2:0] err_row_a2, err_row_b2;
  logic [1:0] solution_count2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int frame_e = 0;

  always #5 clk = ~clk;

  queen_solution_checker #(.CNT_W(8)) dut (
    .clk(clk), .user_reset(user_reset), .row_valid(row_valid), .row_bus(row_bus),
    .row_ready(row_ready), .frame_clear(frame_clear), .busy(busy),
    .result_valid(result_valid), .result_ok(result_ok), .err_code(err_code),
    .err_row_a(err_row_a), .err_row_b(err_row_b), .solution_count(solution_count)
  );

  queen_solution_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .user_reset(user_reset), .row_valid(row_valid), .row_bus(row_bus),
    .row_ready(row_ready2), .frame_clear(frame_clear), .busy(busy2),
    .result_valid(result_valid2), .result_ok(result_ok2), .err_code(err_code2),
    .err_row_a(err_row_a2), .err_row_b(err_row_b2), .solution_count(solution_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference verdict straight from the rules: one-hot rows, then pairs in scan order.
  function automatic void judge(input logic [63:0] bd, output int lat,
                                output logic [1:0] code, output int a, output int b);
    int col [8];
    int k;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] m;
      m = bd[r*8 +: 8];
      if ($countones(m) != 1) begin
        lat = 1; code = 2'b01; a = r; b = r;
        return;
      end
      for (int c = 0; c < 8; c++) if (m[c]) col[r] = c;
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        int d;
        k++;
        d = (col[i] > col[j]) ? col[i] - col[j] : col[j] - col[i];
        if (col[i] == col[j]) begin
          lat = k + 1; code = 2'b10; a = i; b = j;
          return;
        end
        if (d == j - i) begin
          lat = k + 1; code = 2'b11; a = i; b = j;
          return;
        end
      end
    end
    lat = 29; code = 2'b00; a = 0; b = 0;
  endfunction

  bit         m_init = 0, m_busy = 0, m_rv = 0, m_ok = 0;
  logic [1:0] m_code = 0, p_code = 0;
  int         m_a = 0, m_b = 0, p_a = 0, p_b = 0, m_n = 0, m_res = 0;
  int         m_cnt8 = 0, m_cnt2 = 0;
  logic [63:0] m_board = '0;

  always @(posedge clk) begin : model
    int lat, a, b;
    logic [1:0] code;
    logic [63:0] nb;
    cyc <= cyc + 1;
    if (user_reset) begin
      m_init <= 1; m_busy <= 0; m_rv <= 0; m_ok <= 0; m_code <= 0;
      m_a <= 0; m_b <= 0; m_n <= 0; m_cnt8 <= 0; m_cnt2 <= 0;
    end else begin
      m_rv <= 0;
      if (m_busy) begin
        if (cyc + 1 == m_res) begin
          m_rv <= 1; m_busy <= 0;
          m_ok <= (p_code == 2'b00); m_code <= p_code; m_a <= p_a; m_b <= p_b;
          if (p_code == 2'b00) begin
            if (m_cnt8 < 255) m_cnt8 <= m_cnt8 + 1;
            if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
          end
        end
      end else if (frame_clear) begin
        m_n <= 0;
      end else if (row_valid) begin
        nb = m_board;
        nb[m_n*8 +: 8] = row_bus;
        m_board <= nb;
        if (m_n == 7) begin
          judge(nb, lat, code, a, b);
          p_code <= code; p_a <= a; p_b <= b;
          m_res <= cyc + 1 + lat; m_busy <= 1; m_n <= 0;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("row_ready", row_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("result_valid", result_valid, m_rv);
      chk("result_valid2", result_valid2, m_rv);
      chk("result_ok", result_ok, m_ok);
      chk("err_code", err_code, m_code);
      chk("err_row_a", err_row_a, m_a[2:0]);
      chk("err_row_b", err_row_b, m_b[2:0]);
      chk("solution_count", solution_count, m_cnt8[7:0]);
      chk("solution_count2", solution_count2, m_cnt2[1:0]);
    end
  end

  function automatic logic [63:0] mk(input int c [8]);
    logic [63:0] bd;
    bd = '0;
    for (int r = 0; r < 8; r++) bd[r*8 + c[r]] = 1'b1;
    return bd;
  endfunction

  task automatic send_rows(input logic [63:0] bd, input int n, input int hold);
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      row_valid = 1'b1;
      row_bus   = bd[r*8 +: 8];
    end
    @(negedge clk);
    frame_e = cyc;
    if (hold > 0) begin
      row_bus = 8'h00;
      repeat (hold) @(negedge clk);
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int lat, input logic [1:0] code,
                             input int a, input int b);
    int t = 0;
    while (!result_valid && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!result_valid) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_latency"}, cyc - frame_e, lat);
      chk({name, "_code"}, err_code, code);
      chk({name, "_a"}, err_row_a, a);
      chk({name, "_b"}, err_row_b, b);
    end
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    repeat (2) @(negedge clk);
    user_reset = 1'b0;
  endtask

  logic [63:0] legal, bd;
  logic [7:0]  exp_cnt2 [4];

  initial begin
    user_reset = 1'b0; row_valid = 1'b0; frame_clear = 1'b0; row_bus = '0;
    @(negedge clk);
    do_reset();
    chk("reset_ready", row_ready, 1'b1);
    chk("reset_count", solution_count, 8'd0);
    chk("reset_code", err_code, 2'b00);

    legal = mk('{0, 4, 7, 5, 2, 6, 1, 3});
    send_rows(legal, 8, 0);
    wait_result("legal", 29, 2'b00, 0, 0);
    chk("legal_ok", result_ok, 1'b1);
    chk("legal_count", solution_count, 8'd1);

    send_rows(mk('{0, 0, 7, 5, 2, 6, 1, 3}), 8, 0);
    wait_result("col01", 2, 2'b10, 0, 1);
    chk("col01_count", solution_count, 8'd1);

    send_rows(mk('{3, 1, 3, 2, 5, 7, 4, 0}), 8, 0);
    wait_result("col02", 3, 2'b10, 0, 2);

    send_rows(mk('{0, 1, 7, 5, 2, 6, 4, 3}), 8, 0);
    wait_result("diag01", 2, 2'b11, 0, 1);

    bd = legal;
    bd[3*8 +: 8] = 8'h00;
    bd[5*8 +: 8] = 8'h81;
    send_rows(bd, 8, 0);
    wait_result("onehot3", 1, 2'b01, 3, 3);

    bd = legal;
    bd[7*8 +: 8] = 8'h00;
    send_rows(bd, 8, 0);
    wait_result("onehot7", 1, 2'b01, 7, 7);

    send_rows(legal, 3, 0);
    frame_clear = 1'b1; row_valid = 1'b1; row_bus = 8'h01;
    @(negedge clk);
    frame_clear = 1'b0; row_valid = 1'b0;
    send_rows(legal, 8, 0);
    wait_result("after_clear", 29, 2'b00, 0, 0);
    chk("after_clear_count", solution_count, 8'd2);

    send_rows(legal, 8, 5);
    wait_result("busy_offer", 29, 2'b00, 0, 0);
    chk("busy_offer_count", solution_count, 8'd3);

    send_rows(legal, 8, 0);
    repeat (10) @(negedge clk);
    do_reset();
    repeat (40) @(negedge clk);
    chk("midreset_count", solution_count, 8'd0);
    chk("midreset_ready", row_ready, 1'b1);

    exp_cnt2 = '{8'd1, 8'd2, 8'd3, 8'd3};
    for (int n = 0; n < 4; n++) begin
      send_rows(legal, 8, 0);
      wait_result("sat", 29, 2'b00, 0, 0);
      chk("sat_count2", {6'd0, solution_count2}, exp_cnt2[n]);
      chk("sat_count8", solution_count, n + 1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
